// File: rtl/block_ram_multi_word_load_ctrl_pkg.sv
// Shared types and helpers for the multi-word block RAM load/serve controller.
package block_ram_multi_word_load_ctrl_pkg;

  // Controller phases: idle after reset, streaming the load, flushing the
  // last registered write, then serving row reads.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_READY = 2'd3
  } state_t;

  // One bit of the one-hot word decode: is word lane 'lane' selected by
  // the word counter value 'cnt'?
  function automatic logic word_hit(input int unsigned cnt, input int unsigned lane);
    return (cnt == lane);
  endfunction

endpackage

// File: rtl/block_ram_multi_word_load_ctrl_if.sv
// Bus bundle between the weight stream, the two row-read clients, the RAM
// and the controller. The controller connects through the slave modport.
//
// Handshakes: a load beat transfers on a cycle where wr_valid && wr_ready;
// a row read request transfers on a cycle where rdX_req && rdX_ready. A
// requester may hold req/valid as long as it likes; nothing is taken until
// the matching ready is high in the same cycle. rdX_valid is a one-cycle
// pulse marking the RAM read data for one accepted request.
interface block_ram_multi_word_load_ctrl_if
  import block_ram_multi_word_load_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int NUM_WORDS  = 288
);
  localparam int AW = $clog2(DEPTH);

  logic                  start;
  logic [DATA_WIDTH-1:0] wr_data_in;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  loaded;
  logic                  busy;
  logic                  rd0_req;
  logic [AW-1:0]         rd0_addr;
  logic                  rd0_ready;
  logic                  rd0_valid;
  logic                  rd1_req;
  logic [AW-1:0]         rd1_addr;
  logic                  rd1_ready;
  logic                  rd1_valid;
  logic [AW-1:0]         ram_addr_a;
  logic [DATA_WIDTH-1:0] ram_wr_data_a;
  logic [NUM_WORDS-1:0]  ram_wr_en_a;
  logic                  ram_rd_en_a;
  logic [AW-1:0]         ram_addr_b;
  logic                  ram_rd_en_b;
  state_t                state;

  modport master (
    output start, wr_data_in, wr_valid, rd0_req, rd0_addr, rd1_req, rd1_addr,
    input  wr_ready, loaded, busy, rd0_ready, rd0_valid, rd1_ready, rd1_valid,
    input  ram_addr_a, ram_wr_data_a, ram_wr_en_a, ram_rd_en_a,
    input  ram_addr_b, ram_rd_en_b, state
  );

  modport slave (
    input  start, wr_data_in, wr_valid, rd0_req, rd0_addr, rd1_req, rd1_addr,
    output wr_ready, loaded, busy, rd0_ready, rd0_valid, rd1_ready, rd1_valid,
    output ram_addr_a, ram_wr_data_a, ram_wr_en_a, ram_rd_en_a,
    output ram_addr_b, ram_rd_en_b, state
  );

endinterface

// File: rtl/block_ram_read_port_pipe.sv
// Two-stage row read pipeline for one client: accepted request ->
// RAM read enable + address -> valid aligned with RAM read data.
module block_ram_read_port_pipe #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic [AW-1:0] req_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          valid
);

  // Issue the read one cycle after acceptance, flag its data one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      valid   <= 1'b0;
    end else begin
      rd_en <= accept;
      if (accept) rd_addr <= req_addr;
      valid <= rd_en;
    end
  end

endmodule

// File: rtl/block_ram_multi_word_load_ctrl.sv
// Load/serve sequencer for a dual-port block RAM whose rows hold NUM_WORDS
// words: streams the whole RAM in through port A, then serves client 0 on
// port B and client 1 on port A.
module block_ram_multi_word_load_ctrl
  import block_ram_multi_word_load_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int NUM_WORDS  = 288
) (
  input logic clk,
  input logic rst_n,
  block_ram_multi_word_load_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(NUM_WORDS);

  state_t                state;
  state_t                next_state;
  logic [WW-1:0]         word_cnt;
  logic [AW-1:0]         row_cnt;
  logic                  loaded_q;
  logic                  accept;
  logic                  last_word;
  logic                  last_beat;
  logic                  start_load;
  logic                  busy;
  logic [NUM_WORDS-1:0]  wr_en_next;
  logic [NUM_WORDS-1:0]  wr_en_q;
  logic [AW-1:0]         load_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  rd0_accept;
  logic                  rd1_accept;
  logic                  rd0_en;
  logic                  rd1_en;
  logic [AW-1:0]         rd0_addr_q;
  logic [AW-1:0]         rd1_addr_q;
  logic                  rd0_valid_q;
  logic                  rd1_valid_q;

  assign busy       = (state == ST_LOAD) || (state == ST_DRAIN);
  assign accept     = bus.wr_valid && (state == ST_LOAD);
  assign last_word  = (word_cnt == WW'(NUM_WORDS - 1));
  assign last_beat  = accept && last_word && (row_cnt == AW'(DEPTH - 1));
  assign start_load = bus.start && ((state == ST_IDLE) || (state == ST_READY));
  assign rd0_accept = bus.rd0_req && (state == ST_READY);
  assign rd1_accept = bus.rd1_req && (state == ST_READY);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state: start only counts in IDLE/READY; DRAIN lasts one cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (bus.start) next_state = ST_LOAD;
      ST_LOAD:  if (last_beat) next_state = ST_DRAIN;
      ST_DRAIN: next_state = ST_READY;
      ST_READY: if (bus.start) next_state = ST_LOAD;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Word/row load counters and the loaded flag, all restarted by a (re)load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      row_cnt  <= '0;
      loaded_q <= 1'b0;
    end else if (start_load) begin
      word_cnt <= '0;
      row_cnt  <= '0;
      loaded_q <= 1'b0;
    end else begin
      if (accept) begin
        if (last_word) begin
          word_cnt <= '0;
          row_cnt  <= (row_cnt == AW'(DEPTH - 1)) ? '0 : row_cnt + AW'(1);
        end else begin
          word_cnt <= word_cnt + WW'(1);
        end
      end
      if (state == ST_DRAIN) loaded_q <= 1'b1;
    end
  end

  // One-hot lane select for the current word counter.
  always_comb begin
    wr_en_next = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      wr_en_next[w] = word_hit(32'(word_cnt), w);
    end
  end

  // Registered port A write: enables pulse only for an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= '0;
      load_addr_q <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= accept ? wr_en_next : '0;
      if (accept) begin
        load_addr_q <= row_cnt;
        wr_data_q   <= bus.wr_data_in;
      end
    end
  end

  block_ram_read_port_pipe #(.AW(AW)) u_rd0_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (rd0_accept),
    .req_addr (bus.rd0_addr),
    .rd_en    (rd0_en),
    .rd_addr  (rd0_addr_q),
    .valid    (rd0_valid_q)
  );

  block_ram_read_port_pipe #(.AW(AW)) u_rd1_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (rd1_accept),
    .req_addr (bus.rd1_addr),
    .rd_en    (rd1_en),
    .rd_addr  (rd1_addr_q),
    .valid    (rd1_valid_q)
  );

  assign bus.wr_ready      = (state == ST_LOAD);
  assign bus.busy          = busy;
  assign bus.loaded        = loaded_q;
  assign bus.state         = state;
  assign bus.rd0_ready     = rd0_accept;
  assign bus.rd1_ready     = rd1_accept;
  assign bus.rd0_valid     = rd0_valid_q;
  assign bus.rd1_valid     = rd1_valid_q;
  assign bus.ram_addr_b    = rd0_addr_q;
  assign bus.ram_rd_en_b   = rd0_en;
  assign bus.ram_wr_en_a   = wr_en_q;
  assign bus.ram_wr_data_a = wr_data_q;
  assign bus.ram_rd_en_a   = rd1_en;
  // Port A belongs to the loader while busy. The one exception is the first
  // LOAD cycle, where a client 1 read accepted alongside start is issued; no
  // write can be pending then, so the port is free for that read.
  assign bus.ram_addr_a    = (busy && !rd1_en) ? load_addr_q : rd1_addr_q;

endmodule

// File: tb/tb_block_ram_multi_word_load_ctrl.sv
// Directed + randomized bench for block_ram_multi_word_load_ctrl with a
// behavioural dual-port RAM and a row-level reference memory.
module tb_block_ram_multi_word_load_ctrl;
  import block_ram_multi_word_load_ctrl_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NW    = 3;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [NW-1:0][DW-1:0] row_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  row_t ram     [DEPTH];
  row_t ref_mem [DEPTH];
  row_t rd_data_a;
  row_t rd_data_b;

  block_ram_multi_word_load_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)) bus ();

  block_ram_multi_word_load_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // behavioural dual-port RAM with registered read data
  always @(posedge clk) begin
    for (int w = 0; w < NW; w++)
      if (bus.ram_wr_en_a[w]) ram[bus.ram_addr_a][w] <= bus.ram_wr_data_a;
    if (bus.ram_rd_en_a) rd_data_a <= ram[bus.ram_addr_a];
    if (bus.ram_rd_en_b) rd_data_b <= ram[bus.ram_addr_b];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // with requests asserted, everything must read zero while in reset
  task automatic check_reset_outputs(input string pfx);
    bus.rd0_req = 1'b1;
    bus.rd1_req = 1'b1;
    #1;
    check({pfx, "_state"},     bus.state,         ST_IDLE);
    check({pfx, "_wr_ready"},  bus.wr_ready,      0);
    check({pfx, "_loaded"},    bus.loaded,        0);
    check({pfx, "_busy"},      bus.busy,          0);
    check({pfx, "_rd0_ready"}, bus.rd0_ready,     0);
    check({pfx, "_rd1_ready"}, bus.rd1_ready,     0);
    check({pfx, "_rd0_valid"}, bus.rd0_valid,     0);
    check({pfx, "_rd1_valid"}, bus.rd1_valid,     0);
    check({pfx, "_addr_a"},    bus.ram_addr_a,    0);
    check({pfx, "_wdata_a"},   bus.ram_wr_data_a, 0);
    check({pfx, "_wen_a"},     bus.ram_wr_en_a,   0);
    check({pfx, "_ren_a"},     bus.ram_rd_en_a,   0);
    check({pfx, "_addr_b"},    bus.ram_addr_b,    0);
    check({pfx, "_ren_b"},     bus.ram_rd_en_b,   0);
    bus.rd0_req = 1'b0;
    bus.rd1_req = 1'b0;
  endtask

  // driver: stream n beats; mode 0 back-to-back, 1 toggling valid, 2 random
  // valid with random data; base offsets the incrementing data of modes 0/1
  task automatic load_beats(input int n, input int mode, input int base);
    int       k   = 0;
    int       cyc = 0;
    bit       v;
    logic [DW-1:0] d;
    while (k < n && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = (mode == 2) ? DW'($urandom) : DW'(base + k);
      bus.wr_valid   = v;
      bus.wr_data_in = d;
      check("wr_ready_in_load", bus.wr_ready, 1);
      check("rd1_locked_out", bus.rd1_ready, 0);
      @(negedge clk);
      cyc++;
      check("ren_a_while_loading", bus.ram_rd_en_a, 0);
      if (v) begin
        check("wen_a_onehot", bus.ram_wr_en_a, 64'(1) << (k % NW));
        check("addr_a_row", bus.ram_addr_a, k / NW);
        check("wdata_a", bus.ram_wr_data_a, d);
        ref_mem[k / NW][k % NW] = d;
        k++;
      end else begin
        check("wen_a_no_beat", bus.ram_wr_en_a, 0);
      end
    end
    bus.wr_valid = 1'b0;
    check("load_beat_budget", k, n);
  endtask

  // called at the sample right after the final beat's write: DRAIN, then READY
  task automatic finish_load();
    check("drain_busy", bus.busy, 1);
    check("drain_wr_ready", bus.wr_ready, 0);
    check("drain_loaded", bus.loaded, 0);
    check("drain_rd1_ready", bus.rd1_ready, 0);
    @(negedge clk);
    check("ready_loaded", bus.loaded, 1);
    check("ready_busy", bus.busy, 0);
    check("ready_wen_a", bus.ram_wr_en_a, 0);
  endtask

  // both clients issue random requests; expected valids/data delayed by two
  task automatic random_reads(input int n);
    bit   p0[$];
    bit   p1[$];
    row_t e0[$];
    row_t e1[$];
    bit   r0, r1, v0, v1;
    row_t x0, x1;
    logic [AW-1:0] a0, a1;
    for (int c = 0; c < n + 2; c++) begin
      r0 = (c < n) && ($urandom_range(0, 3) != 0);
      r1 = (c < n) && ($urandom_range(0, 3) != 0);
      a0 = AW'($urandom_range(0, DEPTH - 1));
      a1 = AW'($urandom_range(0, DEPTH - 1));
      bus.rd0_req  = r0;
      bus.rd0_addr = a0;
      bus.rd1_req  = r1;
      bus.rd1_addr = a1;
      #1;
      check("rand_rd0_ready", bus.rd0_ready, r0);
      check("rand_rd1_ready", bus.rd1_ready, r1);
      p0.push_back(r0);
      p1.push_back(r1);
      e0.push_back(ref_mem[a0]);
      e1.push_back(ref_mem[a1]);
      @(negedge clk);
      if (p0.size() == 2) begin
        v0 = p0.pop_front();
        v1 = p1.pop_front();
        x0 = e0.pop_front();
        x1 = e1.pop_front();
        check("rand_rd0_valid", bus.rd0_valid, v0);
        check("rand_rd1_valid", bus.rd1_valid, v1);
        if (v0) check("rand_rd0_data", rd_data_b, x0);
        if (v1) check("rand_rd1_data", rd_data_a, x1);
      end
    end
    bus.rd0_req = 1'b0;
    bus.rd1_req = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.wr_data_in = '0;
    bus.wr_valid   = 1'b0;
    bus.rd0_req    = 1'b0;
    bus.rd0_addr   = '0;
    bus.rd1_req    = 1'b0;
    bus.rd1_addr   = '0;
    rst_n          = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE refuses reads
    bus.rd0_req = 1'b1;
    #1;
    check("idle_rd0_refused", bus.rd0_ready, 0);
    bus.rd0_req = 1'b0;

    // first load: 12 back-to-back beats 0x00..0x0B
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("load_busy", bus.busy, 1);
    check("load_loaded_clear", bus.loaded, 0);
    load_beats(DEPTH * NW, 0, 0);
    finish_load();

    // concurrent reads on both clients: rows 2 and 3
    bus.rd0_req  = 1'b1;
    bus.rd0_addr = AW'(2);
    bus.rd1_req  = 1'b1;
    bus.rd1_addr = AW'(3);
    #1;
    check("pair_rd0_ready", bus.rd0_ready, 1);
    check("pair_rd1_ready", bus.rd1_ready, 1);
    @(negedge clk);
    bus.rd0_req = 1'b0;
    bus.rd1_req = 1'b0;
    check("pair_ren_b", bus.ram_rd_en_b, 1);
    check("pair_addr_b", bus.ram_addr_b, 2);
    check("pair_ren_a", bus.ram_rd_en_a, 1);
    check("pair_addr_a", bus.ram_addr_a, 3);
    check("pair_wen_a", bus.ram_wr_en_a, 0);
    check("pair_valid_early", bus.rd0_valid, 0);
    @(negedge clk);
    check("pair_rd0_valid", bus.rd0_valid, 1);
    check("pair_rd1_valid", bus.rd1_valid, 1);
    check("pair_row2", rd_data_b, 24'h080706);
    check("pair_row3", rd_data_a, 24'h0B0A09);
    @(negedge clk);
    check("pair_rd0_valid_pulse", bus.rd0_valid, 0);

    // reload with toggling valid while client 1 is held off
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rd1_req  = 1'b1;
    bus.rd1_addr = AW'(1);
    load_beats(DEPTH * NW, 1, 8'h20);
    finish_load();
    check("first_ready_rd1_ready", bus.rd1_ready, 1);
    @(negedge clk);
    bus.rd1_req = 1'b0;
    check("held_ren_a", bus.ram_rd_en_a, 1);
    check("held_addr_a", bus.ram_addr_a, 1);
    @(negedge clk);
    check("held_rd1_valid", bus.rd1_valid, 1);
    check("held_rd1_data", rd_data_a, ref_mem[1]);

    // start in READY together with a client 0 request
    bus.start    = 1'b1;
    bus.rd0_req  = 1'b1;
    bus.rd0_addr = AW'(0);
    #1;
    check("start_rd0_ready", bus.rd0_ready, 1);
    @(negedge clk);
    bus.start = 1'b0;
    check("start_next_rd0_refused", bus.rd0_ready, 0);
    check("start_loaded_clear", bus.loaded, 0);
    check("start_wr_ready", bus.wr_ready, 1);
    check("start_ren_b", bus.ram_rd_en_b, 1);
    check("start_addr_b", bus.ram_addr_b, 0);
    @(negedge clk);
    bus.rd0_req = 1'b0;
    check("start_rd0_valid", bus.rd0_valid, 1);
    check("start_rd0_data", rd_data_b, ref_mem[0]);
    check("start_refused_no_issue", bus.ram_rd_en_b, 0);

    // reset after the 5th beat of a load
    load_beats(5, 2, 0);
    rst_n = 1'b0;
    check_reset_outputs("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", bus.state, ST_IDLE);

    // full reload from row 0 word 0 with random data and gaps
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    load_beats(DEPTH * NW, 2, 0);
    finish_load();

    // pipelined random reads on both ports
    random_reads(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/block_ram_multi_word_load_ctrl.md
Name: block_ram_multi_word_load_ctrl

Overview:
- Sequences a multi-word dual-port block RAM; each RAM row holds NUM_WORDS words of DATA_WIDTH bits.
- Load phase: serially streams DEPTH*NUM_WORDS words (e.g. conv weights) into the RAM through port A, one word per beat, using one-hot word write enables.
- Serve phase: shares both RAM ports between two row-read clients, giving client 0 port B and client 1 port A. Client 1 is locked out while port A is owned by the loader.
- Sits between the weight DMA stream and the conv engine read logic.

Parameters:
DATA_WIDTH, 8, bits per word
DEPTH, 64, RAM rows; must be >= 2
NUM_WORDS, 288, words per row; must be >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin (re)load of the whole RAM
wr_data_in  in  DATA_WIDTH  load stream word
wr_valid  in  1  load stream valid
wr_ready  out  1  load stream ready
loaded  out  1  RAM contents complete and readable
busy  out  1  load in progress (LOAD or DRAIN)
rd0_req  in  1  client 0 row read request
rd0_addr  in  $clog2(DEPTH)  client 0 row address
rd0_ready  out  1  client 0 request accepted this cycle
rd0_valid  out  1  RAM port B rd_data valid this cycle
rd1_req  in  1  client 1 row read request
rd1_addr  in  $clog2(DEPTH)  client 1 row address
rd1_ready  out  1  client 1 request accepted this cycle
rd1_valid  out  1  RAM port A rd_data valid this cycle
ram_addr_a  out  $clog2(DEPTH)  RAM port A address
ram_wr_data_a  out  DATA_WIDTH  RAM port A write word
ram_wr_en_a  out  NUM_WORDS  RAM port A one-hot word write enable
ram_rd_en_a  out  1  RAM port A read enable
ram_addr_b  out  $clog2(DEPTH)  RAM port B address
ram_rd_en_b  out  1  RAM port B read enable

Behaviour:
- Reset: state IDLE, word_cnt=0, row_cnt=0. All outputs 0.
- States: IDLE, LOAD, DRAIN, READY.
- IDLE --start--> LOAD. READY --start--> LOAD. start in LOAD or DRAIN is ignored.
- Entering LOAD clears word_cnt, row_cnt and loaded.
- wr_ready = (state==LOAD), combinational from state.
- Beat accepted at cycle t (wr_valid && wr_ready) drives, registered, at t+1:
  - ram_wr_en_a = one-hot(word_cnt)
  - ram_addr_a = row_cnt
  - ram_wr_data_a = wr_data_in
- With no accepted beat, ram_wr_en_a=0 the next cycle. wr_valid low simply stalls the load.
- Counters: word_cnt increments per beat. At NUM_WORDS-1 it wraps to 0 and row_cnt increments.
- Final beat (row DEPTH-1, word NUM_WORDS-1) accepted at t:
  - state DRAIN at t+1, while the final write is driven
  - state READY and loaded=1 at t+2
- busy = LOAD or DRAIN. Client requests are not accepted in IDLE, LOAD or DRAIN.
- rd0_ready = rd0_req && state==READY. rd1_ready = rd1_req && state==READY. No arbitration is needed because the clients own separate ports.
- Accepted read at t:
  - at t+1: ram_rd_en_x=1 and ram_addr_x = registered request address
  - at t+2: rdX_valid=1, aligned with RAM rd_data_x
- Back-to-back requests give one read per cycle, fully pipelined.
- ram_addr_a mux: load address in LOAD/DRAIN, rd1 address otherwise.
- ram_rd_en_a is never 1 in a cycle where ram_wr_en_a != 0.
- start sampled in READY while requests are present: those same-cycle requests are still accepted and complete normally, with valids at t+2. Requests from the next cycle onward are refused.
- Reads already in flight when LOAD begins still produce their valid pulse.
- rst_n low mid-load or mid-read: immediate return to reset values. Pipelined valids are squashed and RAM contents are treated as stale (loaded=0).
- Counter widths are $clog2 of the parameter. Wrap compares use NUM_WORDS-1 and DEPTH-1 explicitly, so non-power-of-2 values are legal.

Decomposition:
- Shared package: state encoding localparams (IDLE/LOAD/DRAIN/READY) and a one-hot decode function for word_cnt.
- One sub-module is natural: block_ram_read_port_pipe, the 2-stage req->rd_en/addr->valid pipeline, instantiated once per client.
- Counters and FSM stay in the top.

Test Plan (DATA_WIDTH=8, DEPTH=4, NUM_WORDS=3):
- Reset then start, then 12 back-to-back beats 0x00..0x0B -> ram_wr_en_a sequence 001,010,100 repeating, ram_addr_a 0,0,0,1,...,3; loaded=1 exactly 2 cycles after the beat-0x0B accept.
- Load with wr_valid toggling every other cycle -> each beat written once, no duplicate or skipped one-hot enable; loaded after the 12th accept +2.
- After load, rd0_addr=2 and rd1_addr=3 in the same cycle -> both readys high; ram_rd_en_b/ram_rd_en_a with addr 2/3 at +1; rd0_valid/rd1_valid at +2; model RAM returns row2={0x08,0x07,0x06} and row3={0x0B,0x0A,0x09}.
- rd1_req held during LOAD and DRAIN -> rd1_ready=0 and ram_rd_en_a=0 throughout; accepted in the first READY cycle.
- start in READY concurrent with rd0_req -> that read completes (rd0_valid at +2); next-cycle rd0_req refused; loaded=0 and wr_ready=1 at +1.
- rst_n asserted after the 5th beat -> all outputs 0 immediately; a new start reloads from row 0, word 0.
